// File: rtl/ea_div_pkg.sv
// Shared definitions for the ea_div iterative divider: widths, iteration
// count, special-case result constants, FSM encoding and magnitude helper.
package ea_div_pkg;

  localparam int          DIV_W       = 16;
  localparam int          DIV_ITERS   = 16;
  localparam logic [4:0]  ITER_LOAD   = 5'd16;
  localparam logic [16:1] DZ_QUOT     = 16'hFFFF;
  localparam logic [16:1] OVF_QUOT    = 16'h8000;
  localparam logic [16:1] OVF_DIVISOR = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  // Two's-complement negate of a 16-bit value.
  function automatic logic [16:1] neg16(input logic [16:1] v);
    neg16 = ~v + 16'd1;
  endfunction

  // Magnitude of an operand; only negative when treated as signed.
  function automatic logic [16:1] mag16(input logic [16:1] v, input logic is_signed);
    mag16 = (is_signed && v[16]) ? neg16(v) : v;
  endfunction

endpackage

// File: rtl/ea_div_step.sv
// One non-restoring division step: shift {PR,Q} left by one, then subtract
// the divisor magnitude when PR was non-negative, add it when negative.
// The add/subtract uses the sign of PR before the shift, so the 17-bit
// result stays exact even though the shifted value can wrap.
module ea_div_step (
  input  logic [17:1] pr,
  input  logic        q_msb,
  input  logic [16:1] dmag,
  output logic [17:1] pr_next,
  output logic        q_bit
);

  logic [17:1] shifted;
  logic [17:1] dext;

  // Single add/subtract of the step; new quotient bit is the inverted PR sign.
  always_comb begin
    shifted = {pr[16:1], q_msb};
    dext    = {1'b0, dmag};
    if (!pr[17]) begin
      pr_next = shifted - dext;
    end else begin
      pr_next = shifted + dext;
    end
    q_bit = ~pr_next[17];
  end

endmodule

// File: rtl/ea_div.sv
// Iterative 16-bit signed/unsigned divider, one quotient bit per clock.
// Handshake: start is a one-cycle request sampled only when busy=0 (IDLE or
// DONE state); an accepted start raises busy the next cycle, and done pulses
// for exactly one cycle when quot/rem/dz_/ovf_ are valid. Results and flags
// hold until the next accepted start replaces them.
module ea_div
  import ea_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_,
  input  logic        start,
  input  logic        sgn,
  input  logic [16:1] dividend,
  input  logic [16:1] divisor,
  output logic        busy,
  output logic        done,
  output logic [16:1] quot,
  output logic [16:1] rem,
  output logic        dz_,
  output logic        ovf_
);

  // FSM state is kept as a named enum so checkers can bind to it directly.
  div_state_e  state_q, state_d;

  logic [17:1] pr_q,   pr_d;
  logic [16:1] q_q,    q_d;
  logic [16:1] dmag_q, dmag_d;
  logic [4:0]  cnt_q,  cnt_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [16:1] quot_q, quot_d;
  logic [16:1] rem_q,  rem_d;
  logic        dz_q,   dz_d;
  logic        ovf_q,  ovf_d;

  logic [17:1] step_pr;
  logic        step_qbit;
  logic [16:1] rem_mag;
  logic        is_ovf_case;

  ea_div_step u_step (
    .pr      (pr_q),
    .q_msb   (q_q[16]),
    .dmag    (dmag_q),
    .pr_next (step_pr),
    .q_bit   (step_qbit)
  );

  // Remainder correction folded to 16 bits: a negative final PR lies in
  // [-d,0), so adding d lands in [0,d) and the carry out is never needed.
  always_comb begin
    rem_mag     = pr_q[17] ? (pr_q[16:1] + dmag_q) : pr_q[16:1];
    is_ovf_case = sgn && (dividend == OVF_QUOT) && (divisor == OVF_DIVISOR);
  end

  // Next-state and datapath control; every register holds by default.
  always_comb begin
    state_d = state_q;
    pr_d    = pr_q;
    q_d     = q_q;
    dmag_d  = dmag_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          dz_d  = 1'b1;
          ovf_d = 1'b1;
          if (divisor == '0) begin
            quot_d  = DZ_QUOT;
            rem_d   = dividend;
            dz_d    = 1'b0;
            state_d = S_DONE;
          end else if (is_ovf_case) begin
            quot_d  = OVF_QUOT;
            rem_d   = '0;
            ovf_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            pr_d    = '0;
            q_d     = mag16(dividend, sgn);
            dmag_d  = mag16(divisor, sgn);
            cnt_d   = ITER_LOAD;
            rneg_d  = sgn && dividend[16];
            qneg_d  = sgn && (dividend[16] ^ divisor[16]);
            state_d = S_ITER;
          end
        end
      end
      S_ITER: begin
        pr_d  = step_pr;
        q_d   = {q_q[15:1], step_qbit};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        quot_d  = qneg_q ? neg16(q_q) : q_q;
        rem_d   = rneg_q ? neg16(rem_mag) : rem_mag;
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst_.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= S_IDLE;
      pr_q    <= '0;
      q_q     <= '0;
      dmag_q  <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b1;
      ovf_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      pr_q    <= pr_d;
      q_q     <= q_d;
      dmag_q  <= dmag_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status decoded straight from the state register, so it only moves on clk.
  always_comb begin
    busy = (state_q == S_ITER) || (state_q == S_FIX);
    done = (state_q == S_DONE);
    quot = quot_q;
    rem  = rem_q;
    dz_  = dz_q;
    ovf_ = ovf_q;
  end

endmodule

// File: tb/tb_ea_div.sv
// Scoreboard bench for ea_div: the driver pushes hand-computed results with
// the expected latency and busy length; a negedge monitor pops on done.
module tb_ea_div;

  localparam int EW = 44; // {busy_cycles[5], latency[5], quot[16], rem[16], dz_, ovf_}

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [16:1] dividend = '0;
  logic [16:1] divisor = '0;
  logic        busy, done, dz_, ovf_;
  logic [16:1] quot, rem;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busy_run = 0;
  int done_cnt = 0;

  logic [EW-1:0] exp_q[$];
  int            start_q[$];

  ea_div dut (
    .clk      (clk),
    .rst_     (rst_),
    .start    (start),
    .sgn      (sgn),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quot     (quot),
    .rem      (rem),
    .dz_      (dz_),
    .ovf_     (ovf_)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pop and compare whenever the DUT pulses done
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int sc;
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e  = exp_q.pop_front();
        sc = start_q.pop_front();
        chk("result", 64'({quot, rem, dz_, ovf_}), 64'(e[33:0]));
        chk("latency", 64'(cyc - sc), 64'(e[38:34]));
        chk("busy_cycles", 64'(busy_run), 64'(e[43:39]));
      end
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end
  end

  // driver: call at a negedge; leaves start high across one rising edge
  task automatic issue(input logic [16:1] a, input logic [16:1] b, input logic s,
                       input logic [16:1] eq, input logic [16:1] er,
                       input logic edz, input logic eovf, input bit special);
    logic [4:0] lat;
    logic [4:0] bc;
    lat = special ? 5'd1 : 5'd18;
    bc  = special ? 5'd0 : 5'd17;
    start = 1'b1;
    dividend = a;
    divisor = b;
    sgn = s;
    exp_q.push_back({bc, lat, eq, er, edz, eovf});
    start_q.push_back(cyc);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=0 required=1 (cycle %0d)", cyc);
    end
  endtask

  task automatic run_op(input logic [16:1] a, input logic [16:1] b, input logic s,
                        input logic [16:1] eq, input logic [16:1] er,
                        input logic edz, input logic eovf, input bit special);
    issue(a, b, s, eq, er, edz, eovf, special);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    int c0;
    int d0;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_state", 64'({busy, done, quot, rem, dz_, ovf_}), 64'({1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1}));
    rst_ = 1'b1;
    @(negedge clk);

    // basic unsigned and signed quadrants
    run_op(16'd100, 16'd7, 1'b0, 16'h000E, 16'h0002, 1'b1, 1'b1, 1'b0);
    chk("quot_hold", 64'(quot), 64'(16'h000E));
    run_op(16'hFF9C, 16'h0007, 1'b1, 16'hFFF2, 16'hFFFE, 1'b1, 1'b1, 1'b0);
    run_op(16'h0064, 16'hFFF9, 1'b1, 16'hFFF2, 16'h0002, 1'b1, 1'b1, 1'b0);

    // divide by zero, flag held, then cleared by the next accepted start
    run_op(16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b0, 1'b1, 1'b1);
    chk("dz_hold", 64'(dz_), 64'(1'b0));
    issue(16'd100, 16'd7, 1'b0, 16'h000E, 16'h0002, 1'b1, 1'b1, 1'b0);
    chk("dz_restore", 64'(dz_), 64'(1'b1));
    chk("busy_after_start", 64'(busy), 64'(1'b1));
    wait_done();
    @(negedge clk);

    // signed overflow and boundary operands
    run_op(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b1);
    chk("ovf_hold", 64'(ovf_), 64'(1'b0));
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b0);
    run_op(16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0);
    run_op(16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0);
    run_op(16'h0005, 16'h000A, 1'b0, 16'h0000, 16'h0005, 1'b1, 1'b1, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0);

    // start while busy is ignored (a divide-by-zero request would show)
    issue(16'd100, 16'd7, 1'b0, 16'h000E, 16'h0002, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    dividend = 16'h1234;
    divisor = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);

    // back-to-back: second start presented in the done cycle
    issue(16'h0064, 16'hFFF9, 1'b1, 16'hFFF2, 16'h0002, 1'b1, 1'b1, 1'b0);
    wait_done();
    issue(16'hFF9C, 16'h0007, 1'b1, 16'hFFF2, 16'hFFFE, 1'b1, 1'b1, 1'b0);
    wait_done();
    @(negedge clk);

    // asynchronous reset in the middle of the iterations
    c0 = cyc;
    issue(16'd100, 16'd7, 1'b0, 16'h000E, 16'h0002, 1'b1, 1'b1, 1'b0);
    while (cyc < c0 + 8) @(negedge clk);
    rst_ = 1'b0;
    #1;
    chk("reset_mid_iter", 64'({busy, done, quot, rem, dz_, ovf_}), 64'({1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1}));
    exp_q.delete();
    start_q.delete();
    busy_run = 0;
    d0 = done_cnt;
    @(negedge clk);
    rst_ = 1'b1;
    repeat (25) @(negedge clk);
    chk("no_done_after_reset", 64'(done_cnt - d0), 64'(0));
    run_op(16'hFF9C, 16'h0007, 1'b1, 16'hFFF2, 16'hFFFE, 1'b1, 1'b1, 1'b0);

    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
